// File: rtl/knight_rider_pkg.sv
// rtl/knight_rider_pkg.sv - shared widths, types and PWM duty table for knight_rider_ctrl
package knight_rider_pkg;

  localparam int SEL_W  = 2;
  localparam int PWM_W  = 4;
  localparam int DUTY_W = PWM_W + 1;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [PWM_W-1:0]  pwm_cnt_t;
  typedef logic [DUTY_W-1:0] duty_t;

  // One extra bit so the full-brightness threshold of 16 is representable.
  function automatic duty_t duty_thr(input sel_t sel);
    duty_t thr;
    case (sel)
      2'd0:    thr = 5'd4;
      2'd1:    thr = 5'd8;
      2'd2:    thr = 5'd12;
      default: thr = 5'd16;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/knight_rider_if.sv
// rtl/knight_rider_if.sv - button inputs and scanner/PWM outputs of knight_rider_ctrl
interface knight_rider_if;
  import knight_rider_pkg::*;

  logic rate_btn;
  logic bright_btn;
  logic step_en;
  logic pwm_on;
  sel_t rate_sel;
  sel_t bright_sel;

  modport master (
    output rate_btn, bright_btn,
    input  step_en, pwm_on, rate_sel, bright_sel
  );

  modport slave (
    input  rate_btn, bright_btn,
    output step_en, pwm_on, rate_sel, bright_sel
  );

endinterface

// File: rtl/kr_debounce.sv
// rtl/kr_debounce.sv - two-flop synchroniser, debounce counter and press-edge detector
module kr_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_differ;
  logic             w_done;

  assign w_differ = (r_sync[1] != r_level);
  assign w_done   = w_differ && (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // The press pulse is registered alongside the level flip so the sel
  // registers see it one cycle later, giving DEB_CYCLES+3 end to end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= w_done && r_sync[1];
      if (w_done) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/knight_rider_ctrl.sv
// rtl/knight_rider_ctrl.sv - rate/brightness buttons driving a step strobe and brightness PWM gate
module knight_rider_ctrl
  import knight_rider_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int RATE_BASE  = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  knight_rider_if.slave  bus
);

  localparam int TMR_W = $clog2(RATE_BASE * 8);

  logic             w_rate_press;
  logic             w_bright_press;
  logic [TMR_W-1:0] w_last;

  sel_t             r_rate_sel;
  sel_t             r_bright_sel;
  logic [TMR_W-1:0] r_tmr;
  logic             r_step_en;
  pwm_cnt_t         r_pwm_cnt;
  logic             r_pwm_on;

  kr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rate_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.rate_btn),
    .o_press (w_rate_press)
  );

  kr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_bright_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.bright_btn),
    .o_press (w_bright_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate_sel   <= 2'd0;
      r_bright_sel <= 2'd3;
    end else begin
      if (w_rate_press)
        r_rate_sel <= sel_t'(r_rate_sel + 1'b1);
      if (w_bright_press)
        r_bright_sel <= sel_t'(r_bright_sel + 1'b1);
    end
  end

  // Slowest rate is eight times the base period; every rate is a power of two.
  assign w_last = TMR_W'((RATE_BASE << (3 - int'(r_rate_sel))) - 1);

  // A rate press restarts the period so the first step after a change is a full new period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr     <= '0;
      r_step_en <= 1'b0;
    end else if (w_rate_press) begin
      r_tmr     <= '0;
      r_step_en <= 1'b0;
    end else if (r_tmr == w_last) begin
      r_tmr     <= '0;
      r_step_en <= 1'b1;
    end else begin
      r_tmr     <= r_tmr + 1'b1;
      r_step_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_pwm_on  <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_pwm_on  <= ({1'b0, r_pwm_cnt} < duty_thr(r_bright_sel));
    end
  end

  assign bus.step_en    = r_step_en;
  assign bus.pwm_on     = r_pwm_on;
  assign bus.rate_sel   = r_rate_sel;
  assign bus.bright_sel = r_bright_sel;

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// tb/tb_knight_rider_ctrl.sv - self-checking bench for knight_rider_ctrl with a behavioural model
module tb_knight_rider_ctrl;

  localparam int DEB = 4;
  localparam int RB  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  knight_rider_if bus();

  knight_rider_ctrl #(.DEB_CYCLES(DEB), .RATE_BASE(RB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_n counts clock edges since reset release; steps fall on multiples
  // of the period measured from the last anchor (reset release or rate change).
  int m_n      = 0;
  int m_anchor = 0;
  int m_rate   = 0;
  int m_bright = 3;
  bit m_step   = 1'b0;
  bit m_pwm    = 1'b0;
  bit m_s1[2], m_s2[2], m_deb[2], m_pend[2], m_press[2];
  bit hist[2][DEB];
  int hlen[2];
  bit raw_v[2];
  bit obs_v, alld;

  task automatic model_reset();
    m_n = 0; m_anchor = 0; m_rate = 0; m_bright = 3; m_step = 0; m_pwm = 0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_pend[b] = 0; m_press[b] = 0; hlen[b] = 0;
    end
  endtask

  task automatic model_clock();
    m_n++;
    raw_v[0] = bus.rate_btn;
    raw_v[1] = bus.bright_btn;
    for (int b = 0; b < 2; b++) begin
      obs_v   = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw_v[b];
      for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = obs_v;
      if (hlen[b] < DEB) hlen[b]++;
      alld = (hlen[b] == DEB);
      for (int k = 0; k < DEB; k++) if (hist[b][k] == m_deb[b]) alld = 0;
      m_press[b] = 0;
      if (alld) begin
        m_deb[b]   = !m_deb[b];
        m_press[b] = m_deb[b];
      end
    end
    if (m_pend[0]) begin
      m_rate   = (m_rate + 1) % 4;
      m_anchor = m_n;
    end
    m_step = (m_n > m_anchor) && ((m_n - m_anchor) % (RB << (3 - m_rate)) == 0);
    m_pwm  = ((m_n - 1) % 16) < 4 * (m_bright + 1);
    if (m_pend[1]) m_bright = (m_bright + 1) % 4;
    m_pend[0] = m_press[0];
    m_pend[1] = m_press[1];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_clock();
    end
  end

  initial forever begin
    @(negedge clk);
    check("rate_sel",   bus.rate_sel,   m_rate);
    check("bright_sel", bus.bright_sel, m_bright);
    check("step_en",    bus.step_en,    m_step);
    check("pwm_on",     bus.pwm_on,     m_pwm);
  end

  // Holds the buttons for 'hold' cycles and reports cycles from drive to each sel change
  // and from the rate change to the following step strobe (-1 when absent).
  task automatic pulse(input bit r, input bit b, input int hold,
                       output int d_rate, output int d_bright, output int d_step);
    int e0;
    logic [1:0] r0, b0;
    d_rate = -1; d_bright = -1; d_step = -1;
    @(posedge clk); #1;
    e0 = m_n; r0 = bus.rate_sel; b0 = bus.bright_sel;
    bus.rate_btn = r; bus.bright_btn = b;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == hold) begin bus.rate_btn = 0; bus.bright_btn = 0; end
      if (d_rate >= 0 && d_step < 0 && bus.step_en) d_step = m_n - (e0 + d_rate);
      if (d_rate < 0 && bus.rate_sel != r0) d_rate = m_n - e0;
      if (d_bright < 0 && bus.bright_sel != b0) d_bright = m_n - e0;
    end
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    repeat (16) begin @(negedge clk); if (bus.pwm_on) hi++; end
  endtask

  initial begin
    int first, cnt, lo, dr, db, ds, hi;
    int exp_seq[3] = '{2, 3, 0};
    int exp_ds[3]  = '{16, 8, 64};
    bus.rate_btn = 0; bus.bright_btn = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rate_sel",   bus.rate_sel,   0);
    check("reset_bright_sel", bus.bright_sel, 3);
    check("reset_pwm_on",     bus.pwm_on,     0);
    #2 rst_n = 1;

    @(posedge clk);
    first = -1; cnt = 0; lo = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.step_en) begin if (first < 0) first = m_n; cnt++; end
      if (!bus.pwm_on) lo++;
    end
    check("first_step_cycle", first, 64);
    check("steps_in_200",     cnt,   3);
    check("pwm_low_cycles",   lo,    0);

    pulse(1, 0, 10, dr, db, ds);
    check("rate_latency",   dr, 7);
    check("rate_sel_first", bus.rate_sel, 1);
    check("step_after_chg", ds, 32);
    for (int k = 0; k < 3; k++) begin
      pulse(1, 0, 10, dr, db, ds);
      check("rate_seq",          bus.rate_sel, exp_seq[k]);
      check("step_after_chg_seq", ds, exp_ds[k]);
    end

    pulse(1, 0, 3, dr, db, ds);
    check("glitch_no_change", dr, -1);
    repeat (6) begin
      bus.rate_btn = 1; repeat (3) @(posedge clk); #1;
      bus.rate_btn = 0; repeat (3) @(posedge clk); #1;
    end
    repeat (10) @(posedge clk); #1;
    check("toggle_rate_sel", bus.rate_sel, 0);

    pulse(0, 1, 10, dr, db, ds);
    check("bright_latency", db, 7);
    check("bright_wrap",    bus.bright_sel, 0);
    count_pwm(hi);
    check("pwm_hi_sel0", hi, 4);
    pulse(0, 1, 10, dr, db, ds);
    check("bright_sel1", bus.bright_sel, 1);
    count_pwm(hi);
    check("pwm_hi_sel1", hi, 8);

    pulse(1, 1, 10, dr, db, ds);
    check("both_rate_lat",   dr, 7);
    check("both_bright_lat", db, 7);
    check("both_bright_sel", bus.bright_sel, 2);
    pulse(1, 0, 10, dr, db, ds);
    check("rate_sel_two", bus.rate_sel, 2);

    @(posedge clk); #1;
    bus.rate_btn = 1;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("async_rate_sel",   bus.rate_sel,   0);
    check("async_bright_sel", bus.bright_sel, 3);
    check("async_step_en",    bus.step_en,    0);
    check("async_pwm_on",     bus.pwm_on,     0);
    bus.rate_btn = 0;
    @(posedge clk);
    #3 rst_n = 1;
    repeat (20) @(posedge clk); #1;
    check("no_press_after_rst", bus.rate_sel, 0);

    repeat (300) begin
      bus.rate_btn   = 1'($urandom_range(0, 1));
      bus.bright_btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) @(posedge clk);
      #1;
    end
    bus.rate_btn = 0; bus.bright_btn = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/knight_rider_ctrl.md
KNIGHT_RIDER_CTRL -- requirements
Module: knight_rider_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept a button level change (range 2..255).
REQ-002 SHALL have parameter RATE_BASE, default 1024: step period in clk cycles at the fastest rate (power of two, at least 4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rate_btn, input, 1 bit: raw, asynchronous rate button; high = pressed.
REQ-006 SHALL have port bright_btn, input, 1 bit: raw, asynchronous brightness button; high = pressed.
REQ-007 SHALL have port step_en, output, 1 bit: single-cycle strobe telling the LED scanner to advance one position.
REQ-008 SHALL have port pwm_on, output, 1 bit: LED enable gate for brightness PWM.
REQ-009 SHALL have port rate_sel, output, 2 bits: current rate setting; 0 = slowest, 3 = fastest.
REQ-010 SHALL have port bright_sel, output, 2 bits: current brightness setting; 0 = dimmest, 3 = full.

Function
REQ-011 SHALL pass each button through a two-flop synchroniser before any other use.
REQ-012 SHALL debounce each synchronised button: the debounced level updates only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles; any return to the old level clears the count.
REQ-013 SHALL generate a press event on a 0->1 transition of the debounced level only; release generates no event.
REQ-014 SHALL advance rate_sel by 1 modulo 4 on each rate press event; 3 wraps to 0.
REQ-015 SHALL advance bright_sel by 1 modulo 4 on each brightness press event; 3 wraps to 0.
REQ-016 SHALL produce total latency from a raw button rising edge, held stable, to the sel output change of exactly DEB_CYCLES+3 cycles.
REQ-017 SHALL handle simultaneous rate and brightness press events independently in the same cycle.
REQ-018 SHALL run a step timer with period P = RATE_BASE * 2^(3-rate_sel) cycles.
REQ-019 SHALL assert step_en for exactly one cycle when the timer equals P-1, with the timer wrapping to 0 on that cycle.
REQ-020 SHALL clear the step timer to 0, with step_en low, in the cycle in which rate_sel changes, so the first step after a change comes exactly P(new) cycles later.
REQ-021 SHALL size the step timer width from RATE_BASE*8 with no overflow at any rate.
REQ-022 SHALL run a free-running 4-bit PWM counter, 0..15 wrapping, that is never affected by button activity.
REQ-023 SHALL set the PWM duty threshold D by bright_sel: 0 -> 4, 1 -> 8, 2 -> 12, 3 -> 16.
REQ-024 SHALL drive pwm_on registered and equal to (pwm_cnt < D); bright_sel = 3 gives pwm_on constantly high.
REQ-025 SHALL apply a bright_sel change at the next pwm_on update without restarting the PWM counter.

Reset
REQ-026 SHALL, while rst_n is low, immediately force: rate_sel = 0, bright_sel = 3, step_en = 0, pwm_on = 0, all counters = 0, synchroniser and debounced levels = 0.
REQ-027 SHALL drive pwm_on = 1 on the first clock edge after rst_n deasserts, with the first step_en following RATE_BASE*8 cycles after deassertion.
REQ-028 SHALL produce no press event when reset asserts mid-debounce or while a button is held, and none after release while the button stays held (debounced level starts at 0, so a held button yields one press after DEB_CYCLES+3 cycles).

Structure
REQ-029 SHALL place the duty threshold table, the sel width (2) and the PWM counter width (4) in shared package knight_rider_pkg.
REQ-030 SHALL implement the synchroniser, debounce counter and press-edge detector as sub-module kr_debounce, instantiated once per button.

Verification (DEB_CYCLES=4, RATE_BASE=8)
REQ-031 SHALL cover reset release: step_en at cycle 64 after deassertion then every 64; pwm_on constantly 1.
REQ-032 SHALL cover a rate_btn high for 10 cycles: rate_sel goes 0->1 exactly 7 cycles after the edge; the next step_en comes 32 cycles after the change. Four such presses give rate_sel sequence 1, 2, 3, 0.
REQ-033 SHALL cover a rate_btn glitch of 3 cycles, and toggling with a period of 6 cycles: rate_sel and step timing unchanged.
REQ-034 SHALL cover one bright_btn press: bright_sel goes 3->0; pwm_on is high for 4 of every 16 cycles. After a second press it is high for 8 of 16.
REQ-035 SHALL cover both buttons pressed on the same cycle: rate_sel and bright_sel both increment on the same cycle.
REQ-036 SHALL cover rst_n pulsed low for 1 cycle mid-debounce with rate_sel = 2: all outputs return to reset values asynchronously and no press is registered.
